// File: rtl/shift_reg_pkg.sv
// shift_reg_pkg: shared direction encoding for shift_reg
package shift_reg_pkg;
  typedef logic dir_t;
  localparam dir_t DIR_LEFT  = 1'b0;
  localparam dir_t DIR_RIGHT = 1'b1;
endpackage

// File: rtl/shift_reg_next.sv
// shift_reg_next: next-state mux for shift_reg; SHIFT_REG_PLOAD_EN adds a parallel-load path
module shift_reg_next
  import shift_reg_pkg::*;
#(
  parameter int MSB = 16
) (
  input  logic [MSB-1:0] cur_i,
  input  logic           d_i,
  input  logic           en_i,
  input  dir_t           dir_i,
`ifdef SHIFT_REG_PLOAD_EN
  input  logic           load_i,
  input  logic [MSB-1:0] pdata_i,
`endif
  output logic [MSB-1:0] next_o
);
  logic [MSB-1:0] shift_d;
  always_comb begin
    shift_d = (dir_i == DIR_RIGHT) ? {d_i, cur_i[MSB-1:1]} : {cur_i[MSB-2:0], d_i};
`ifdef SHIFT_REG_PLOAD_EN
    next_o = load_i ? pdata_i : en_i ? shift_d : cur_i;
`else
    next_o = en_i ? shift_d : cur_i;
`endif
  end
endmodule

// File: rtl/shift_reg.sv
// shift_reg: serial-in bidirectional shift register; SHIFT_REG_PLOAD_EN adds load/pdata
module shift_reg
  import shift_reg_pkg::*;
#(
  parameter int MSB = 16
) (
  input  logic           clk,
  input  logic           rstn,
  input  logic           d,
  input  logic           en,
  input  logic           dir,
`ifdef SHIFT_REG_PLOAD_EN
  input  logic           load,
  input  logic [MSB-1:0] pdata,
`endif
  output logic [MSB-1:0] out
);
  logic [MSB-1:0] out_q, out_d;
  shift_reg_next #(.MSB(MSB)) u_next (
    .cur_i   (out_q),
    .d_i     (d),
    .en_i    (en),
    .dir_i   (dir_t'(dir)),
`ifdef SHIFT_REG_PLOAD_EN
    .load_i  (load),
    .pdata_i (pdata),
`endif
    .next_o  (out_d)
  );
  always_ff @(posedge clk) begin
    if (!rstn) out_q <= '0;
    else       out_q <= out_d;
  end
  assign out = out_q;
endmodule

// File: tb/tb_shift_reg.sv
// tb_shift_reg: directed and randomized checks of shift_reg against an arithmetic model
module tb_shift_reg;
  localparam int W = 16;
  logic clk = 1'b0, rstn = 1'b0, d = 1'b0, en = 1'b0, dir = 1'b0;
  logic load = 1'b0;
  logic [W-1:0] pdata = '0;
  logic [W-1:0] out, m;
  int n_chk = 0, n_pass = 0;

  shift_reg #(.MSB(W)) dut (
    .clk   (clk),
    .rstn  (rstn),
    .d     (d),
    .en    (en),
    .dir   (dir),
`ifdef SHIFT_REG_PLOAD_EN
    .load  (load),
    .pdata (pdata),
`endif
    .out   (out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic step(input logic r, input logic e, input logic dr, input logic dd);
    rstn = r; en = e; dir = dr; d = dd;
    @(posedge clk);
    #1;
    if (!r) m = '0;
`ifdef SHIFT_REG_PLOAD_EN
    else if (load) m = pdata;
`endif
    else if (e && !dr) m = W'((m * 2) + dd);
    else if (e && dr) m = (m / 2) + (dd ? W'(1 << (W - 1)) : W'(0));
    check("model", out, m);
  endtask

  task automatic fill(input logic [W-1:0] v);
    for (int i = W - 1; i >= 0; i--) step(1, 1, 0, v[i]);
  endtask

  initial begin
    m = '0;
    step(0, 1, 0, 1); check("rst0", out, 16'h0000);
    step(0, 1, 0, 1); check("rst1", out, 16'h0000);
    for (int i = 0; i < 4; i++) step(1, 1, 0, 1);
    check("left_ones", out, 16'h000F);
    step(1, 1, 1, 1); step(1, 1, 1, 1); check("right_ones", out, 16'hC003);
    step(1, 1, 1, 0); check("right_zero", out, 16'h6001);
    step(0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(1, 1, 0, ~i[0]);
    check("alt4", out, 16'h000A);
    for (int i = 4; i < 16; i++) step(1, 1, 0, ~i[0]);
    check("alt16", out, 16'hAAAA);
    step(1, 1, 0, 1); check("msb_drop", out, 16'h5555);
    fill(16'h1234); check("fill1234", out, 16'h1234);
    for (int i = 0; i < 5; i++) begin
      step(1, 0, i[0], ~i[0]);
      check("hold", out, 16'h1234);
    end
    fill(16'hFFFF); check("fillFFFF", out, 16'hFFFF);
    step(0, 1, 0, 1); check("mid_rst", out, 16'h0000);
    step(1, 1, 0, 1); check("after_rst", out, 16'h0001);
`ifdef SHIFT_REG_PLOAD_EN
    load = 1; pdata = 16'hBEEF;
    step(1, 1, 1, 0); check("pload", out, 16'hBEEF);
    step(0, 1, 0, 1); check("rst_over_load", out, 16'h0000);
    load = 0;
`endif
    for (int i = 0; i < 400; i++) begin
`ifdef SHIFT_REG_PLOAD_EN
      load = ($urandom_range(0, 15) == 0);
      pdata = W'($urandom);
`endif
      step($urandom_range(0, 19) != 0, 1'($urandom), 1'($urandom), 1'($urandom));
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
